phibin_to_relphi: RTL and testbench

Maps a global phi bin back into the relative-phi frame of a given start-phi sector. This is the inverse of the sector-relative-phi-to-phi-bin conversion. It sits between the jet-finder output and any per-sector consumer that works in 12-bit relative phi. The data path is a two-stage valid/ready pipeline with full backpressure. Each output beat carries the bin-centre relative phi, an out-of-window flag and a pass-through tag. A saturating counter tracks out-of-window beats.

---
 rtl/phibin_to_relphi.sv | 139 +++++++++++++
 tb/tb_phibin_to_relphi.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/phibin_to_relphi.sv
// phibin_to_relphi
// Maps a global phi bin into the 12-bit relative-phi frame of a start-phi
// sector. Two-stage valid/ready pipeline with full backpressure, plus a
// saturating counter of out-of-window beats that leave the block.
//
// Handshake: a beat moves across an interface on a rising edge where
// valid & ready are both 1. valid is never withdrawn before its beat has
// moved, and the beat's payload holds stable while valid is high and
// ready is low. ready may depend combinationally on the downstream ready.
module phibin_to_relphi #(
    parameter int N_BINS    = 27,
    parameter int BIN_WIDTH = 1364,
    parameter int TAG_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       phi_bin,
    input  logic [4:0]       start_phi,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      rel_phi,
    output logic             out_of_window,
    output logic [TAG_W-1:0] out_tag,
    input  logic             err_clr,
    output logic [15:0]      err_count
);

    // Bin-centre offsets of the three in-window bins, fixed at elaboration.
    localparam logic [5:0]  NB      = 6'(N_BINS);
    localparam logic [11:0] REL_POS = 12'(BIN_WIDTH);
    localparam logic [11:0] REL_NEG = 12'(-BIN_WIDTH);

    // Stage 1 registers
    logic             s1_valid;
    logic [5:0]       s1_d;
    logic             s1_illegal;
    logic [TAG_W-1:0] s1_tag;

    // Pipeline advance conditions
    logic s2_adv;
    logic s1_adv;

    // Stage 1 combinational results
    logic [5:0] pb6;
    logic [5:0] sp6;
    logic [5:0] d_next;
    logic       illegal_next;

    // Stage 2 combinational results
    logic [11:0] rel_next;
    logic        oow_next;

    // Error counter increment condition
    logic err_inc;

    // Advance whenever the downstream slot is empty or being drained.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
    end

    // Modular distance from the sector start; 6 bits hold phi_bin + N_BINS.
    always_comb begin
        pb6          = {1'b0, phi_bin};
        sp6          = {1'b0, start_phi};
        illegal_next = (pb6 >= NB) || (sp6 >= NB);
        if (pb6 >= sp6) begin
            d_next = pb6 - sp6;
        end else begin
            d_next = pb6 + NB - sp6;
        end
    end

    // Stage 1 register: capture distance, legality and tag on acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s1_d       <= '0;
            s1_illegal <= 1'b0;
            s1_tag     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_d       <= d_next;
                s1_illegal <= illegal_next;
                s1_tag     <= in_tag;
            end
        end
    end

    // Distance 0/1/2 maps to the window's bin centres; anything else is out.
    always_comb begin
        rel_next = 12'h000;
        oow_next = 1'b1;
        if (!s1_illegal) begin
            case (s1_d)
                6'd0: begin rel_next = REL_NEG; oow_next = 1'b0; end
                6'd1: begin rel_next = 12'h000; oow_next = 1'b0; end
                6'd2: begin rel_next = REL_POS; oow_next = 1'b0; end
                default: begin rel_next = 12'h000; oow_next = 1'b1; end
            endcase
        end
    end

    // Stage 2 output register: payload only changes when the slot advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            rel_phi       <= '0;
            out_of_window <= 1'b0;
            out_tag       <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                rel_phi       <= rel_next;
                out_of_window <= oow_next;
                out_tag       <= s1_tag;
            end
        end
    end

    assign err_inc = out_valid && out_ready && out_of_window;

    // Saturating error counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (err_inc && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_phibin_to_relphi.sv
// Testbench for phibin_to_relphi: directed vectors, a spec-level model with
// an expected queue, a per-cycle compare process and literal spot checks.
module tb_phibin_to_relphi;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  phi_bin;
    logic [4:0]  start_phi;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] rel_phi;
    logic        out_of_window;
    logic [7:0]  out_tag;
    logic        err_clr;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    // expected beat = {out_of_window, rel_phi, tag}
    logic [20:0] exp_q[$];
    logic [15:0] mdl_err = 16'd0;
    logic        prev_stall = 1'b0;

    phibin_to_relphi #(.N_BINS(27), .BIN_WIDTH(1364), .TAG_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .phi_bin(phi_bin), .start_phi(start_phi), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .rel_phi(rel_phi), .out_of_window(out_of_window), .out_tag(out_tag),
        .err_clr(err_clr), .err_count(err_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Relative phi of the bin centre is (d - 1) * BIN_WIDTH for d in 0..2.
    function automatic logic [20:0] model(input int pb, input int sp, input logic [7:0] tg);
        int d;
        int r;
        logic [11:0] rel;
        if (pb >= 27 || sp >= 27) return {1'b1, 12'h000, tg};
        d = (pb - sp + 27) % 27;
        if (d > 2) return {1'b1, 12'h000, tg};
        r   = (d - 1) * 1364;
        rel = r[11:0];
        return {1'b0, rel, tg};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            mdl_err    = 16'd0;
            prev_stall = 1'b0;
        end else begin
            chk("err_count", err_count, mdl_err);
            if (prev_stall) chk("valid_held", out_valid, 1'b1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    chk("out_of_window", out_of_window, exp_q[0][20]);
                    chk("rel_phi", rel_phi, exp_q[0][19:8]);
                    chk("out_tag", out_tag, exp_q[0][7:0]);
                end
            end
            // model next state of err_count
            if (err_clr) begin
                mdl_err = 16'd0;
            end else if (out_valid && out_ready && exp_q.size() != 0 && exp_q[0][20]
                         && mdl_err != 16'hFFFF) begin
                mdl_err = mdl_err + 16'd1;
            end
            if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) exp_q.push_back(model(int'(phi_bin), int'(start_phi), in_tag));
            prev_stall = out_valid && !out_ready;
        end
    end

    // ---------------- driver tasks ----------------
    // Offer one beat; returns #1 after the edge that accepted it.
    task automatic send(input logic [4:0] pb, input logic [4:0] sp, input logic [7:0] tg);
        logic ok;
        int n;
        n = 0;
        in_valid = 1'b1; phi_bin = pb; start_phi = sp; in_tag = tg;
        do begin
            @(negedge clk) ok = in_ready;
            @(posedge clk);
            n++;
        end while (!ok && n < 200);
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
        #1 in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b0; in_valid = 1'b0; phi_bin = '0; start_phi = '0; in_tag = '0;
        out_ready = 1'b1; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        // reset state
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_rel_phi", rel_phi, 12'h000);
        chk("rst_oow", out_of_window, 1'b0);
        chk("rst_out_tag", out_tag, 8'h00);
        chk("rst_err_count", err_count, 16'h0000);
        reset = 1'b1;
        step();

        // centre bin: 2-cycle latency
        send(5'd5, 5'd4, 8'h11);
        chk("centre_lat_before", out_valid, 1'b0);
        step();
        chk("centre_valid", out_valid, 1'b1);
        chk("centre_rel", rel_phi, 12'h000);
        chk("centre_oow", out_of_window, 1'b0);
        chk("centre_tag", out_tag, 8'h11);

        // wrap-around
        send(5'd1, 5'd26, 8'h22);
        step();
        chk("wrap_d2_rel", rel_phi, 12'h554);
        chk("wrap_d2_oow", out_of_window, 1'b0);
        send(5'd25, 5'd25, 8'h33);
        step();
        chk("wrap_d0_rel", rel_phi, 12'hAAC);
        chk("wrap_d0_oow", out_of_window, 1'b0);
        step();
        chk("err_before_oow", err_count, 16'd0);

        // out of window and illegal
        send(5'd10, 5'd3, 8'h44);
        step();
        chk("oow_d7_flag", out_of_window, 1'b1);
        chk("oow_d7_rel", rel_phi, 12'h000);
        send(5'd27, 5'd0, 8'h55);
        step();
        chk("illegal_flag", out_of_window, 1'b1);
        chk("illegal_rel", rel_phi, 12'h000);
        step();
        chk("err_after_two", err_count, 16'd2);
        send(5'd31, 5'd0, 8'h66);
        step();
        chk("third_err_valid", out_valid, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_wins", err_count, 16'd0);

        // backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; phi_bin = 5'd5; start_phi = 5'd4; in_tag = 8'h01;
        @(negedge clk) chk("bp_ready1", in_ready, 1'b1);
        @(posedge clk) #1 in_tag = 8'h02;
        @(negedge clk) chk("bp_ready2", in_ready, 1'b1);
        @(posedge clk) #1 in_tag = 8'h03;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_full_ready", in_ready, 1'b0);
            chk("bp_hold_tag", out_tag, 8'h01);
        end
        @(posedge clk) #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1'b1);
        chk("bp_out_tag1", out_tag, 8'h01);
        @(posedge clk) #1 in_valid = 1'b0;
        @(negedge clk) chk("bp_out_tag2", out_tag, 8'h02);
        @(negedge clk) chk("bp_out_tag3", out_tag, 8'h03);
        @(negedge clk) chk("bp_drained", out_valid, 1'b0);

        // saturation
        @(posedge clk) #1;
        in_valid = 1'b1; phi_bin = 5'd31; start_phi = 5'd0; in_tag = 8'hEE;
        repeat (65540) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) step();
        chk("sat_value", err_count, 16'hFFFF);
        send(5'd30, 5'd2, 8'hEF);
        repeat (3) step();
        chk("sat_stays", err_count, 16'hFFFF);

        // reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; phi_bin = 5'd6; start_phi = 5'd5; in_tag = 8'hA1;
        @(posedge clk) #1 in_tag = 8'hA2;
        @(posedge clk) #1 in_valid = 1'b0;
        @(negedge clk) chk("mid_pre_valid", out_valid, 1'b1);
        @(posedge clk) #3 reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_err_count", err_count, 16'h0000);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        @(posedge clk) #1 reset = 1'b1;
        out_ready = 1'b1;
        step();
        send(5'd4, 5'd4, 8'h77);
        chk("post_rst_lat_before", out_valid, 1'b0);
        step();
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_rel", rel_phi, 12'hAAC);
        chk("post_rst_tag", out_tag, 8'h77);
        repeat (3) step();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
